// File: rtl/matrix_addsub_seq.sv
// matrix_addsub_seq
// Sequential add/subtract of two square signed matrices (N x N, N = matrix_size+2,
// N <= MAX_DIM), dense row-major packing, LANES elements written per clock.
// Optional build macro: MATRIX_ADDSUB_SAT_EN -- when defined, overflowing elements
// saturate to the DATA_W signed limits; otherwise they wrap by truncation.
// ovf_mask / overflow behave the same in both builds.
module matrix_addsub_seq #(
    parameter int DATA_W  = 8,
    parameter int MAX_DIM = 5,
    parameter int LANES   = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              op,
    input  logic [2:0]                        matrix_size,
    input  logic [MAX_DIM*MAX_DIM*DATA_W-1:0] matrix_A,
    input  logic [MAX_DIM*MAX_DIM*DATA_W-1:0] matrix_B,
    output logic                              busy,
    output logic                              done,
    output logic                              size_err,
    output logic [MAX_DIM*MAX_DIM*DATA_W-1:0] result_out,
    output logic                              overflow,
    output logic [MAX_DIM*MAX_DIM-1:0]        ovf_mask
);

    localparam int ELEMS = MAX_DIM * MAX_DIM;
    localparam int MAT_W = ELEMS * DATA_W;
    // Element counters: N*N <= 81 and index never exceeds 81+LANES, so 8 bits suffice
    localparam logic [3:0] MAX_N = 4'(MAX_DIM);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Sign-extended add or subtract; the DATA_W+1 bit result is always exact
    function automatic logic [DATA_W:0] wide_addsub(input logic [DATA_W-1:0] a,
                                                    input logic [DATA_W-1:0] b,
                                                    input logic              sub);
        logic [DATA_W:0] a_x;
        logic [DATA_W:0] b_x;
        a_x = {a[DATA_W-1], a};
        b_x = {b[DATA_W-1], b};
        if (sub) begin
            wide_addsub = a_x - b_x;
        end else begin
            wide_addsub = a_x + b_x;
        end
    endfunction

    // Exact result does not fit DATA_W bits when its top two bits disagree
    function automatic logic is_ovf(input logic [DATA_W:0] s);
        is_ovf = s[DATA_W] ^ s[DATA_W-1];
    endfunction

    // Reduce an exact result to DATA_W bits (saturating or wrapping)
    function automatic logic [DATA_W-1:0] fit_elem(input logic [DATA_W:0] s);
`ifdef MATRIX_ADDSUB_SAT_EN
        if (!is_ovf(s)) begin
            fit_elem = s[DATA_W-1:0];
        end else if (s[DATA_W]) begin
            fit_elem = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            fit_elem = {1'b0, {(DATA_W-1){1'b1}}};
        end
`else
        fit_elem = s[DATA_W-1:0];
`endif
    endfunction

    state_e             state_q, state_d;
    logic [MAT_W-1:0]   a_q, a_d;
    logic [MAT_W-1:0]   b_q, b_d;
    logic               op_q, op_d;
    logic [7:0]         nn_q, nn_d;
    logic [7:0]         idx_q, idx_d;
    logic [MAT_W-1:0]   result_q, result_d;
    logic [ELEMS-1:0]   ovf_mask_q, ovf_mask_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               size_err_q, size_err_d;

    logic [3:0]         n_s;
    logic [7:0]         nn_s;
    logic               last_s;
    logic [7:0]         lane_idx_s [LANES];
    logic [DATA_W-1:0]  lane_res_s [LANES];
    logic               lane_ovf_s [LANES];

    // Requested dimension, its element count and the final-batch test
    always_comb begin
        n_s    = {1'b0, matrix_size} + 4'd2;
        nn_s   = {4'd0, n_s} * {4'd0, n_s};
        last_s = ((idx_q + 8'(LANES)) >= nn_q);
    end

    // Per-lane operand fetch and arithmetic for the batch starting at idx_q
    always_comb begin
        logic [MAT_W-1:0]  a_sh;
        logic [MAT_W-1:0]  b_sh;
        logic [DATA_W:0]   wide;
        a_sh = {MAT_W{1'b0}};
        b_sh = {MAT_W{1'b0}};
        wide = {(DATA_W+1){1'b0}};
        for (int l = 0; l < LANES; l++) begin
            lane_idx_s[l] = idx_q + 8'(l);
            a_sh          = a_q >> ({24'd0, lane_idx_s[l]} * DATA_W);
            b_sh          = b_q >> ({24'd0, lane_idx_s[l]} * DATA_W);
            wide          = wide_addsub(a_sh[DATA_W-1:0], b_sh[DATA_W-1:0], op_q);
            lane_res_s[l] = fit_elem(wide);
            lane_ovf_s[l] = is_ovf(wide);
        end
    end

    // Control FSM next state, operand capture and batch write-back
    always_comb begin
        logic hit;
        hit        = 1'b0;
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        nn_d       = nn_q;
        idx_d      = idx_q;
        result_d   = result_q;
        ovf_mask_d = ovf_mask_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        size_err_d = size_err_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d        = matrix_A;
                    b_d        = matrix_B;
                    op_d       = op;
                    nn_d       = nn_s;
                    idx_d      = 8'd0;
                    result_d   = {MAT_W{1'b0}};
                    ovf_mask_d = {ELEMS{1'b0}};
                    if (n_s > MAX_N) begin
                        // Oversized request: report and finish without computing
                        size_err_d = 1'b1;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        state_d    = ST_DONE;
                    end else begin
                        size_err_d = 1'b0;
                        busy_d     = 1'b1;
                        done_d     = 1'b0;
                        state_d    = ST_RUN;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Each element takes the lane that maps onto it, if that lane is active
                for (int e = 0; e < ELEMS; e++) begin
                    for (int l = 0; l < LANES; l++) begin
                        hit = (lane_idx_s[l] == 8'(e)) && (8'(e) < nn_q);
                        result_d[e*DATA_W +: DATA_W] = hit ? lane_res_s[l]
                                                           : result_d[e*DATA_W +: DATA_W];
                        ovf_mask_d[e] = hit ? lane_ovf_s[l] : ovf_mask_d[e];
                    end
                end
                idx_d = idx_q + 8'(LANES);
                if (last_s) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            a_q        <= {MAT_W{1'b0}};
            b_q        <= {MAT_W{1'b0}};
            op_q       <= 1'b0;
            nn_q       <= 8'd0;
            idx_q      <= 8'd0;
            result_q   <= {MAT_W{1'b0}};
            ovf_mask_q <= {ELEMS{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            size_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            nn_q       <= nn_d;
            idx_q      <= idx_d;
            result_q   <= result_d;
            ovf_mask_q <= ovf_mask_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            size_err_q <= size_err_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign size_err   = size_err_q;
    assign result_out = result_q;
    assign ovf_mask   = ovf_mask_q;
    assign overflow   = |ovf_mask_q;

endmodule

// File: tb/tb_matrix_addsub_seq.sv
// Testbench for matrix_addsub_seq: two instances (LANES=1 and LANES=4) share
// the same stimulus; an integer-arithmetic reference model supplies expectations.
module tb_matrix_addsub_seq;

    localparam int DATA_W  = 8;
    localparam int MAX_DIM = 5;
    localparam int ELEMS   = MAX_DIM * MAX_DIM;
    localparam int MAT_W   = ELEMS * DATA_W;
    localparam int SMAX    = 127;
    localparam int SMIN    = -128;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             op = 1'b0;
    logic [2:0]       matrix_size = 3'd0;
    logic [MAT_W-1:0] matrix_A = '0;
    logic [MAT_W-1:0] matrix_B = '0;

    logic             busy1, done1, serr1, ovf1;
    logic [MAT_W-1:0] res1;
    logic [ELEMS-1:0] mask1;
    logic             busy4, done4, serr4, ovf4;
    logic [MAT_W-1:0] res4;
    logic [ELEMS-1:0] mask4;

    int checks = 0;
    int errors = 0;

    logic [MAT_W-1:0] exp_res;
    logic [ELEMS-1:0] exp_mask;
    bit               exp_err;
    int               exp_nn;

    always #5 clk = ~clk;

    matrix_addsub_seq #(.DATA_W(DATA_W), .MAX_DIM(MAX_DIM), .LANES(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .op(op), .matrix_size(matrix_size),
        .matrix_A(matrix_A), .matrix_B(matrix_B), .busy(busy1), .done(done1),
        .size_err(serr1), .result_out(res1), .overflow(ovf1), .ovf_mask(mask1)
    );

    matrix_addsub_seq #(.DATA_W(DATA_W), .MAX_DIM(MAX_DIM), .LANES(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start), .op(op), .matrix_size(matrix_size),
        .matrix_A(matrix_A), .matrix_B(matrix_B), .busy(busy4), .done(done4),
        .size_err(serr4), .result_out(res4), .overflow(ovf4), .ovf_mask(mask4)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [MAT_W-1:0] rand_mat();
        logic [MAT_W-1:0] m;
        m = '0;
        for (int i = 0; i < ELEMS; i++) m[i*DATA_W +: DATA_W] = 8'($urandom_range(0, 255));
        return m;
    endfunction

    // Reference: plain signed integer arithmetic per element
    task automatic build_model(input logic op_i, input logic [2:0] msz,
                               input logic [MAT_W-1:0] a_i, input logic [MAT_W-1:0] b_i);
        int n, av, bv, s, r;
        n        = int'(msz) + 2;
        exp_nn   = n * n;
        exp_err  = (n > MAX_DIM);
        exp_res  = '0;
        exp_mask = '0;
        if (!exp_err) begin
            for (int i = 0; i < exp_nn; i++) begin
                av = $signed(a_i[i*DATA_W +: DATA_W]);
                bv = $signed(b_i[i*DATA_W +: DATA_W]);
                s  = op_i ? (av - bv) : (av + bv);
                r  = s;
`ifdef MATRIX_ADDSUB_SAT_EN
                if (s > SMAX) r = SMAX;
                else if (s < SMIN) r = SMIN;
`endif
                exp_res[i*DATA_W +: DATA_W] = r[DATA_W-1:0];
                exp_mask[i] = (s > SMAX) || (s < SMIN);
            end
        end
    endtask

    task automatic observe(input string pfx, input int lanes, input int t,
                           input logic b, input logic d, input logic se,
                           input logic [MAT_W-1:0] res, input logic [ELEMS-1:0] mask,
                           input logic ov, inout int bcnt, inout int dt);
        int k;
        k = (exp_nn + lanes - 1) / lanes;
        if (b) bcnt++;
        if (d && dt == 0) begin
            dt = t;
            check({pfx, "_done_latency"}, 256'(t), exp_err ? 256'(1) : 256'(k + 1));
            check({pfx, "_busy_cycles"}, 256'(bcnt), exp_err ? 256'(0) : 256'(k));
            check({pfx, "_size_err"}, 256'(se), 256'(exp_err));
            check({pfx, "_result"}, 256'(res), 256'(exp_res));
            check({pfx, "_ovf_mask"}, 256'(mask), 256'(exp_mask));
            check({pfx, "_overflow"}, 256'(ov), 256'(|exp_mask));
        end
    endtask

    // Called at a negedge; issues one request and follows both instances to completion
    task automatic run_req(input logic op_i, input logic [2:0] msz,
                           input logic [MAT_W-1:0] a_i, input logic [MAT_W-1:0] b_i,
                           input bit pulse_mid);
        int t, b1, b4, d1, d4;
        build_model(op_i, msz, a_i, b_i);
        op = op_i; matrix_size = msz; matrix_A = a_i; matrix_B = b_i; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; op = ~op_i; matrix_size = 3'($urandom_range(0, 7));
        matrix_A = rand_mat(); matrix_B = rand_mat();
        t = 1; b1 = 0; b4 = 0; d1 = 0; d4 = 0;
        while ((d1 == 0 || d4 == 0) && t < 100) begin
            observe("l1", 1, t, busy1, done1, serr1, res1, mask1, ovf1, b1, d1);
            observe("l4", 4, t, busy4, done4, serr4, res4, mask4, ovf4, b4, d4);
            start = (pulse_mid && t == 2) ? 1'b1 : 1'b0;
            @(negedge clk);
            t++;
        end
        check("completed_in_time", 256'((d1 != 0) && (d4 != 0)), 256'(1));
        check("l1_done_pulse_end", 256'(done1), 256'(0));
        check("l4_done_pulse_end", 256'(done4), 256'(0));
        check("l1_result_hold", 256'(res1), 256'(exp_res));
        check("l4_result_hold", 256'(res4), 256'(exp_res));
    endtask

    initial begin
        logic [MAT_W-1:0] va, vb;
        logic [2:0]       msz;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_busy", 256'({busy1, busy4}), 256'(0));
        check("rst_done", 256'({done1, done4}), 256'(0));
        check("rst_size_err", 256'({serr1, serr4}), 256'(0));
        check("rst_overflow", 256'({ovf1, ovf4}), 256'(0));
        check("rst_result", 256'(res1 | res4), 256'(0));
        check("rst_mask", 256'(mask1 | mask4), 256'(0));
        rst = 1'b0;
        @(negedge clk);

        // 5x5 add, A[i]=i+10, B[i]=i, element 24 overflows; start pulsed mid-run
        va = '0; vb = '0;
        for (int i = 0; i < ELEMS; i++) begin
            va[i*DATA_W +: DATA_W] = 8'(i + 10);
            vb[i*DATA_W +: DATA_W] = 8'(i);
        end
        va[24*DATA_W +: DATA_W] = 8'd100;
        vb[24*DATA_W +: DATA_W] = 8'd100;
        run_req(1'b0, 3'd3, va, vb, 1'b1);

        // 2x2 subtract after the 5x5 run; upper elements must read zero
        va = rand_mat(); vb = rand_mat();
        va[0 +: 32] = {8'd40, 8'd30, 8'd20, 8'd10};
        vb[0 +: 32] = {8'd20, 8'd15, 8'd10, 8'd5};
        run_req(1'b1, 3'd0, va, vb, 1'b0);

        // 3x3 subtract with -128 - 1 in element 0
        va = rand_mat(); vb = rand_mat();
        for (int i = 2; i < 9; i++) begin
            va[i*DATA_W +: DATA_W] = 8'(i);
            vb[i*DATA_W +: DATA_W] = 8'd2;
        end
        va[0 +: 16] = {8'd100, 8'h80};
        vb[0 +: 16] = {8'd10, 8'd1};
        run_req(1'b1, 3'd1, va, vb, 1'b0);

        // Oversized requests, then a legal one that clears size_err
        run_req(1'b0, 3'd4, rand_mat(), rand_mat(), 1'b0);
        run_req(1'b1, 3'd7, rand_mat(), rand_mat(), 1'b0);
        run_req(1'b0, 3'd2, rand_mat(), rand_mat(), 1'b0);

        // Random requests, back to back
        for (int r = 0; r < 10; r++) begin
            msz = 3'($urandom_range(0, 7));
            run_req(1'($urandom_range(0, 1)), msz, rand_mat(), rand_mat(), 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a 5x5 run
        op = 1'b0; matrix_size = 3'd3; matrix_A = rand_mat(); matrix_B = rand_mat(); start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_busy", 256'({busy1, busy4}), 256'(0));
        check("midrst_result", 256'(res1 | res4), 256'(0));
        check("midrst_mask", 256'(mask1 | mask4), 256'(0));
        check("midrst_overflow", 256'({ovf1, ovf4}), 256'(0));
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("midrst_no_done", 256'({done1, done4}), 256'(0));
        end

        // Normal operation after reset
        run_req(1'b1, 3'd3, rand_mat(), rand_mat(), 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
